ct_had_regacc_ctrl: RTL

CT_HAD_REGACC_CTRL -- requirements
Module: ct_had_regacc_ctrl

---
 rtl/ct_had_regacc_pkg.sv | 19 +
 rtl/ct_had_rr_arb2.sv | 28 ++
 rtl/ct_had_regacc_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ct_had_regacc_pkg.sv
// Shared widths, watchdog limit and FSM encoding for the HAD register-access
// controller and its arbiter.
package ct_had_regacc_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 64;
  localparam int WDOG_W = 8;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 8'd255;

  localparam int REQ_JTAG = 0;
  localparam int REQ_CORE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JACC = 2'd1,
    CACC = 2'd2
  } state_e;

endpackage

// File: rtl/ct_had_rr_arb2.sv
// Two-requester round-robin arbiter; priority only rotates when both requesters
// contend, and the last-winner flag starts on the core so JTAG wins the first tie.
module ct_had_rr_arb2 (
  input  logic       forever_cpuclk,
  input  logic       cpurst_b,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last_core;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_core ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      last_core <= 1'b1;
    end else if (upd && (req == 2'b11)) begin
      last_core <= gnt[1];
    end
  end

endmodule

// File: rtl/ct_had_regacc_ctrl.sv
// Serialises JTAG update-DR accesses and core write requests onto one shared
// register port, with overflow/timeout sticky status.
module ct_had_regacc_ctrl
  import ct_had_regacc_pkg::*;
(
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              update_dr_sync,
  input  logic              update_ir_sync,
  input  logic              ir_hacr_rw,
  input  logic [ADDR_W-1:0] ir_hacr_rs,
  input  logic [DATA_W-1:0] dr_wdata,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              reg_wen,
  output logic              reg_ren,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_rdata_vld,
  output logic              ctrl_busy,
  output logic              ctrl_ovf,
  output logic              ctrl_tout
);

  state_e            state;
  logic              dr_d;
  logic              ir_d;
  logic              dr_edge;
  logic              ir_edge;
  logic              jtag_pend;
  logic              slot_rw;
  logic [ADDR_W-1:0] slot_rs;
  logic [DATA_W-1:0] slot_wdata;
  logic [WDOG_W-1:0] wdog;
  logic              in_acc;
  logic              wdog_exp;
  logic              acc_done;
  logic              jtag_done;
  logic              jtag_take;
  logic              core_req_eff;
  logic [1:0]        arb_req;
  logic [1:0]        arb_gnt;
  logic              ent_rw;
  logic [ADDR_W-1:0] ent_rs;
  logic [DATA_W-1:0] ent_wdata;

  assign dr_edge   = update_dr_sync & ~dr_d;
  assign ir_edge   = update_ir_sync & ~ir_d;
  assign in_acc    = (state != IDLE);
  assign wdog_exp  = in_acc & ~reg_ack & (wdog == WDOG_LIMIT);
  assign acc_done  = in_acc & (reg_ack | wdog_exp);
  assign jtag_done = (state == JACC) & acc_done;
  assign jtag_take = dr_edge & (~jtag_pend | jtag_done);

  // The core holds its request through the grant pulse, so mask it there.
  assign core_req_eff = core_req & ~core_gnt;
  assign arb_req[REQ_JTAG] = jtag_pend | jtag_take;
  assign arb_req[REQ_CORE] = core_req_eff;

  // A fresh edge in IDLE is served straight from the JTAG inputs.
  assign ent_rw    = jtag_pend ? slot_rw    : ir_hacr_rw;
  assign ent_rs    = jtag_pend ? slot_rs    : ir_hacr_rs;
  assign ent_wdata = jtag_pend ? slot_wdata : dr_wdata;

  assign ctrl_busy = in_acc | jtag_pend;

  ct_had_rr_arb2 u_arb (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .req            (arb_req),
    .upd            (state == IDLE),
    .gnt            (arb_gnt)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      dr_d       <= 1'b0;
      ir_d       <= 1'b0;
      jtag_pend  <= 1'b0;
      slot_rw    <= 1'b0;
      slot_rs    <= '0;
      slot_wdata <= '0;
      ctrl_ovf   <= 1'b0;
      ctrl_tout  <= 1'b0;
    end else begin
      dr_d <= update_dr_sync;
      ir_d <= update_ir_sync;
      if (jtag_take) begin
        jtag_pend  <= 1'b1;
        slot_rw    <= ir_hacr_rw;
        slot_rs    <= ir_hacr_rs;
        slot_wdata <= dr_wdata;
      end else if (jtag_done) begin
        jtag_pend <= 1'b0;
      end
      if (ir_edge) begin
        ctrl_ovf  <= 1'b0;
        ctrl_tout <= 1'b0;
      end else begin
        if (dr_edge && jtag_pend && !jtag_done) ctrl_ovf <= 1'b1;
        if (wdog_exp) ctrl_tout <= 1'b1;
      end
    end
  end

  // Access FSM: register-port outputs are loaded on entry and cleared on exit,
  // so they stay constant for the whole access.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state          <= IDLE;
      wdog           <= '0;
      reg_wen        <= 1'b0;
      reg_ren        <= 1'b0;
      reg_addr       <= '0;
      reg_wdata      <= '0;
      core_gnt       <= 1'b0;
      jtag_rdata     <= '0;
      jtag_rdata_vld <= 1'b0;
    end else begin
      core_gnt       <= 1'b0;
      jtag_rdata_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_gnt[REQ_JTAG]) begin
            state     <= JACC;
            wdog      <= '0;
            reg_ren   <= ent_rw;
            reg_wen   <= ~ent_rw;
            reg_addr  <= ent_rs;
            reg_wdata <= ent_wdata;
          end else if (arb_gnt[REQ_CORE]) begin
            state     <= CACC;
            wdog      <= '0;
            reg_ren   <= 1'b0;
            reg_wen   <= 1'b1;
            reg_addr  <= core_addr;
            reg_wdata <= core_wdata;
          end
        end
        JACC, CACC: begin
          if (acc_done) begin
            state     <= IDLE;
            reg_wen   <= 1'b0;
            reg_ren   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            if (state == CACC) begin
              core_gnt <= 1'b1;
            end else if (reg_ren && reg_ack) begin
              jtag_rdata     <= reg_rdata;
              jtag_rdata_vld <= 1'b1;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
